// File: rtl/generator_seq.sv
// generator_seq: time-multiplexed Q-format ReLU/hard-tanh generator network on one MAC
module generator_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC = 16,
  parameter int N_Z = 2,
  parameter int N_HIDDEN = 3,
  parameter int N_OUT = 9
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N_Z*WIDTH-1:0]             z,
  input  logic [N_Z*N_HIDDEN*WIDTH-1:0]    w_L1,
  input  logic [N_HIDDEN*WIDTH-1:0]        b_L1,
  input  logic [N_HIDDEN*N_OUT*WIDTH-1:0]  w_L2,
  input  logic [N_OUT*WIDTH-1:0]           b_L2,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [N_OUT*WIDTH-1:0]           x
);
  localparam int CW = $clog2(N_Z + N_HIDDEN + N_OUT + 1);
  localparam int PW = 2 * WIDTH;
  localparam int AW = 2 * WIDTH + 4;
  localparam int SW = 2 * WIDTH + 5;
  localparam logic signed [WIDTH-1:0] WMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] WMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0] SMAX = SW'(WMAX);
  localparam logic signed [SW-1:0] SMIN = SW'(WMIN);
  localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;
  localparam logic signed [WIDTH-1:0] NEG = -ONE;
  typedef enum logic [1:0] {IDLE, LAYER1, LAYER2, DONE} state_t;
  state_t state;
  logic [CW-1:0] ii, ni;
  logic signed [AW-1:0] acc;
  logic signed [WIDTH-1:0] zr [N_Z];
  logic signed [WIDTH-1:0] h [N_HIDDEN];
  logic signed [WIDTH-1:0] a, w, b, sat, act;
  logic signed [PW-1:0] p;
  logic signed [SW-1:0] s;
  logic l1, fin, lastn;
  // Operand selection: ii == fan-in marks the finalize cycle of the current neuron
  always_comb begin
    l1 = state == LAYER1;
    fin = ii == (l1 ? CW'(N_Z) : CW'(N_HIDDEN));
    lastn = ni == (l1 ? CW'(N_HIDDEN - 1) : CW'(N_OUT - 1));
    a = '0;
    w = '0;
    b = '0;
    for (int k = 0; k < N_Z; k++) if (l1 && ii == CW'(k)) a = zr[k];
    for (int k = 0; k < N_HIDDEN; k++) if (!l1 && ii == CW'(k)) a = h[k];
    for (int k = 0; k < N_Z*N_HIDDEN; k++)
      if (l1 && N_Z*int'(ni) + int'(ii) == k) w = w_L1[k*WIDTH +: WIDTH];
    for (int k = 0; k < N_HIDDEN*N_OUT; k++)
      if (!l1 && N_HIDDEN*int'(ni) + int'(ii) == k) w = w_L2[k*WIDTH +: WIDTH];
    for (int k = 0; k < N_HIDDEN; k++) if (l1 && ni == CW'(k)) b = b_L1[k*WIDTH +: WIDTH];
    for (int k = 0; k < N_OUT; k++) if (!l1 && ni == CW'(k)) b = b_L2[k*WIDTH +: WIDTH];
    p = PW'(a) * PW'(w);
    s = (SW'(acc) >>> FRAC) + SW'(b);
    sat = s > SMAX ? WMAX : s < SMIN ? WMIN : s[WIDTH-1:0];
    act = l1 ? (sat < 0 ? '0 : sat) : (sat > ONE ? ONE : sat < NEG ? NEG : sat);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      x <= '0;
      acc <= '0;
      ii <= '0;
      ni <= '0;
      for (int k = 0; k < N_Z; k++) zr[k] <= '0;
      for (int k = 0; k < N_HIDDEN; k++) h[k] <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          for (int k = 0; k < N_Z; k++) zr[k] <= z[k*WIDTH +: WIDTH];
          state <= LAYER1;
          in_ready <= 1'b0;
          acc <= '0;
          ii <= '0;
          ni <= '0;
        end
        LAYER1, LAYER2: if (!fin) begin
          acc <= acc + AW'(p);
          ii <= ii + CW'(1);
        end else begin
          acc <= '0;
          ii <= '0;
          ni <= lastn ? '0 : ni + CW'(1);
          for (int k = 0; k < N_HIDDEN; k++) if (l1 && ni == CW'(k)) h[k] <= act;
          for (int k = 0; k < N_OUT; k++) if (!l1 && ni == CW'(k)) x[k*WIDTH +: WIDTH] <= act;
          if (lastn) begin
            state <= l1 ? LAYER2 : DONE;
            out_valid <= !l1;
          end
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/generator_seq.md
Name: generator_seq

Overview:
- Time-multiplexed fixed-point generator network. Maps a latent vector z (N_Z samples) through one ReLU hidden layer (N_HIDDEN neurons) to an N_OUT-sample output vector x, a 3x3 patch by default.
- The patch feeds the discriminator input a_1..a_9.
- Uses a single multiply-accumulate unit sequenced by an FSM.
- Valid/ready handshake on input and output.

Parameters:
- WIDTH, 32, sample/weight/bias width, signed two's complement.
- FRAC, 16, fractional bits (Q16.16; 1.0 = 0x00010000).
- N_Z, 2, latent inputs.
- N_HIDDEN, 3, hidden-layer neurons.
- N_OUT, 9, output neurons.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  z valid.
- in_ready  out  1  block can accept z.
- z  in  N_Z*WIDTH  latent vector; z_k = z[(k+1)*WIDTH-1 : k*WIDTH].
- w_L1  in  N_Z*N_HIDDEN*WIDTH  hidden weights; neuron j, input k at word index N_Z*j+k.
- b_L1  in  N_HIDDEN*WIDTH  hidden biases; word j.
- w_L2  in  N_HIDDEN*N_OUT*WIDTH  output weights; neuron k, input j at word index N_HIDDEN*k+j.
- b_L2  in  N_OUT*WIDTH  output biases; word k.
- out_valid  out  1  x valid.
- out_ready  in  1  consumer accepts x.
- x  out  N_OUT*WIDTH  output vector; x_k at word k.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE, in_ready=1, out_valid=0, x=0.
  - Hidden registers, accumulator and counters cleared.
  - A reset asserted mid-computation aborts it immediately; no partial x is ever presented.
- FSM states: IDLE, LAYER1, LAYER2, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, z is latched into internal registers and the FSM goes to LAYER1.
  - z may change after the accept edge.
- Weights and biases are sampled live and must be held stable from accept until out_valid. Behaviour when they change mid-operation is not defined.
- Per-neuron schedule:
  - One MAC cycle per input: acc += a*w, full 2*WIDTH signed product, 2*WIDTH+4-bit accumulator.
  - Then one finalize cycle:
    - s = (acc >>> FRAC) + b, arithmetic shift, truncation toward -inf.
    - s is saturated to the signed WIDTH range.
    - The activation is applied.
    - acc is cleared.
- LAYER1:
  - N_HIDDEN neurons, inputs z, activation ReLU (s<0 -> 0).
  - Results go to h_j.
  - Takes N_HIDDEN*(N_Z+1) cycles (9 by default).
- LAYER2:
  - N_OUT neurons, inputs h, activation hard-tanh: clamp to [-(1<<FRAC), +(1<<FRAC)].
  - Results go to the x_k register.
  - Takes N_OUT*(N_HIDDEN+1) cycles (36 by default).
- Latency:
  - out_valid rises exactly N_HIDDEN*(N_Z+1) + N_OUT*(N_HIDDEN+1) cycles after the accept edge (45 by default).
  - The last finalize edge enters DONE.
- x register behaviour:
  - x words are updated only during LAYER2 finalize cycles.
  - x holds the previous result until overwritten.
  - Downstream must qualify x with out_valid.
- DONE:
  - out_valid=1, in_ready=0.
  - x stable while out_ready=0; indefinite backpressure allowed.
  - On out_valid&&out_ready, go to IDLE; out_valid=0 and in_ready=1 from the next cycle.
  - The output handshake and a new input accept never occur in the same cycle.
- in_valid is ignored while in_ready=0.
- in_ready and out_valid are never high simultaneously.
- Counters:
  - Input index wraps at N_Z (layer 1) or N_HIDDEN (layer 2).
  - Neuron index wraps at N_HIDDEN / N_OUT and triggers the state transition.
  - Counters are reset on entry to each layer.

Test Plan:
- Reset with rst_n=0 asynchronously, no clock edge -> in_ready=1, out_valid=0, x=0 immediately after assertion.
- Bias-only path:
  - Stimulus: all weights 0, b_L1=0, b_L2 word k = k*0x4000.
  - Required x: x0=0, x1=0x4000, x2=0x8000, x3=0xC000, x4..x8=0x10000 (clamped).
  - out_valid rises exactly 45 cycles after accept.
- Full datapath:
  - Stimulus: z=(0x10000,0x20000), w_L1 all 0x10000, b_L1=0 -> h=0x30000 each; w_L2 all 0x1000, b_L2=0.
  - Required: all x=0x9000.
- ReLU and lower clamp:
  - Stimulus: w_L1 all 0xFFFF0000 (-1.0) -> h=0; b_L2 words 0,1 = 0xFFFF8000, rest 0xFFFE0000.
  - Required: x0=x1=0xFFFF8000, x2..x8=0xFFFF0000.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid while toggling in_valid.
  - Required: x and out_valid stable, in_ready=0, no new accept.
  - Then pulse out_ready for 1 cycle -> out_valid=0 and in_ready=1 from the next edge.
- Mid-operation reset:
  - Stimulus: assert rst_n=0 on cycle 20 after accept, release, then run the full-datapath case.
  - Required: out_valid never pulses for the aborted job; new result x=0x9000 after 45 cycles.
